// File: rtl/sevenseg_capture_pkg.sv
// sevenseg_capture_pkg: segment encodings, decode result type and FSM states shared with sevenseg_driver.
package sevenseg_capture_pkg;
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [3:0] BLANK_CODE = 4'd12;
   localparam logic [0:0] ST_SETTLE = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;
   typedef struct packed {
      logic       legal;
      logic       is_blank;
      logic [3:0] digit;
   } seg_decode_t;
endpackage

// File: rtl/sevenseg_capture_if.sv
// sevenseg_capture_if: segment bus, control and recovered-digit status of the capture block.
interface sevenseg_capture_if #(parameter int CNT_W = 8);
   logic [6:0]       seg_in;
   logic             enable;
   logic             clear_status;
   logic [3:0]       value;
   logic             blank;
   logic             value_valid;
   logic             update_pulse;
   logic             bad_pattern;
   logic [CNT_W-1:0] change_count;
   modport master (output seg_in, enable, clear_status,
                   input  value, blank, value_valid, update_pulse, bad_pattern, change_count);
   modport slave  (input  seg_in, enable, clear_status,
                   output value, blank, value_valid, update_pulse, bad_pattern, change_count);
endinterface

// File: rtl/sevenseg_pattern_decode.sv
// sevenseg_pattern_decode: inverse of the sevenseg_driver encoding; anything it cannot emit is not legal.
module sevenseg_pattern_decode
   import sevenseg_capture_pkg::*;
(
   input  logic [6:0]  pattern,
   output seg_decode_t dec
);
   always_comb begin
      dec = '{legal: 1'b1, is_blank: 1'b0, digit: 4'd0};
      case (pattern)
         SEG_0:     dec.digit = 4'd0;
         SEG_1:     dec.digit = 4'd1;
         SEG_2:     dec.digit = 4'd2;
         SEG_3:     dec.digit = 4'd3;
         SEG_4:     dec.digit = 4'd4;
         SEG_5:     dec.digit = 4'd5;
         SEG_6:     dec.digit = 4'd6;
         SEG_7:     dec.digit = 4'd7;
         SEG_8:     dec.digit = 4'd8;
         SEG_9:     dec.digit = 4'd9;
         SEG_BLANK: dec = '{legal: 1'b1, is_blank: 1'b1, digit: BLANK_CODE};
         default:   dec.legal = 1'b0;
      endcase
   end
endmodule

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: synchronises a 7-segment bus, accepts a pattern once stable, and decodes it back to a digit.
module sevenseg_capture
   import sevenseg_capture_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input logic           clk,
   input logic           reset,
   sevenseg_capture_if.slave bus
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);

   logic [SYNC_STAGES-1:0][6:0] sync_q, sync_d;
   logic [0:0]       state_q, state_d;
   logic [6:0]       cand_q, cand_d, acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             acc_valid_q, acc_valid_d;
   logic [3:0]       value_q, value_d;
   logic             blank_q, blank_d, valid_q, valid_d, pulse_q, pulse_d, bad_q, bad_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [6:0]       sync;
   logic             accept;
   seg_decode_t      dec;

   assign sync = sync_q[SYNC_STAGES-1];

   // On every acceptance the candidate equals the current sync sample, so decode sync directly.
   sevenseg_pattern_decode u_dec (.pattern(sync), .dec(dec));

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], bus.seg_in};
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      acc_valid_d = acc_valid_q;
      value_d     = value_q;
      blank_d     = blank_q;
      valid_d     = valid_q;
      pulse_d     = 1'b0;
      bad_d       = bus.clear_status ? 1'b0 : bad_q;
      count_d     = bus.clear_status ? '0 : count_q;
      accept      = 1'b0;
      if (!bus.enable) begin
         state_d = ST_SETTLE;
         cnt_d   = '0;
      end else if (state_q == ST_LOCKED) begin
         if (sync != acc_q) begin
            state_d = ST_SETTLE;
            cand_d  = sync;
            cnt_d   = CW'(1);
            accept  = STABLE_CYCLES == 1;
         end
      end else if (sync != cand_q) begin
         cand_d = sync;
         cnt_d  = CW'(1);
         accept = STABLE_CYCLES == 1;
      end else begin
         cnt_d  = cnt_q + CW'(1);
         accept = cnt_q == CW'(STABLE_CYCLES - 1);
      end
      if (accept) begin
         state_d     = ST_LOCKED;
         acc_d       = sync;
         acc_valid_d = 1'b1;
         if (!(acc_valid_q && sync == acc_q)) begin
            if (dec.legal) begin
               value_d = dec.digit;
               blank_d = dec.is_blank;
               valid_d = 1'b1;
               pulse_d = 1'b1;
               count_d = &count_d ? count_d : count_d + CNT_W'(1);
            end else begin
               bad_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q      <= '0;
         state_q     <= ST_SETTLE;
         cand_q      <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         acc_valid_q <= 1'b0;
         value_q     <= '0;
         blank_q     <= 1'b0;
         valid_q     <= 1'b0;
         pulse_q     <= 1'b0;
         bad_q       <= 1'b0;
         count_q     <= '0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         acc_valid_q <= acc_valid_d;
         value_q     <= value_d;
         blank_q     <= blank_d;
         valid_q     <= valid_d;
         pulse_q     <= pulse_d;
         bad_q       <= bad_d;
         count_q     <= count_d;
      end
   end

   assign bus.value        = value_q;
   assign bus.blank        = blank_q;
   assign bus.value_valid  = valid_q;
   assign bus.update_pulse = pulse_q;
   assign bus.bad_pattern  = bad_q;
   assign bus.change_count = count_q;
endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture: run-length reference model checked every cycle on two instances (8-bit and 2-bit counters).
module tb_sevenseg_capture;
   localparam int S = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] seg = 7'h00;
   logic       en = 1'b1;
   logic       clr = 1'b0;
   int         vectors = 0;
   int         miscompares = 0;

   sevenseg_capture_if #(.CNT_W(8)) bus8 ();
   sevenseg_capture_if #(.CNT_W(2)) bus2 ();
   assign bus8.seg_in = seg;
   assign bus8.enable = en;
   assign bus8.clear_status = clr;
   assign bus2.seg_in = seg;
   assign bus2.enable = en;
   assign bus2.clear_status = clr;

   sevenseg_capture #(.CNT_W(8)) u8 (.clk(clk), .reset(reset), .bus(bus8));
   sevenseg_capture #(.CNT_W(2)) u2 (.clk(clk), .reset(reset), .bus(bus2));

   always #5 clk = ~clk;

   logic [6:0] digits [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   logic [6:0] pipe0 = 0, pipe1 = 0, last = 0, m_acc = 0, s;
   int         run = 0, d, m_val = 0, m_c8 = 0, m_c2 = 0;
   bit         m_accv = 0, m_blank = 0, m_valid = 0, m_pulse = 0, m_bad = 0;

   // A pattern is accepted when the synchronised bus shows it on S consecutive enabled edges.
   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         pipe0 = 0; pipe1 = 0; last = 0; run = 0; m_acc = 0; m_accv = 0;
         m_val = 0; m_blank = 0; m_valid = 0; m_pulse = 0; m_bad = 0; m_c8 = 0; m_c2 = 0;
      end else begin
         s = pipe1; pipe1 = pipe0; pipe0 = seg;
         m_pulse = 0;
         if (clr) begin m_bad = 0; m_c8 = 0; m_c2 = 0; end
         if (!en) run = 0;
         else begin
            run = (run > 0 && s == last) ? run + 1 : 1;
            last = s;
            if (run == S && !(m_accv && s == m_acc)) begin
               m_acc = s; m_accv = 1; d = -1;
               for (int i = 0; i < 10; i++) if (digits[i] == s) d = i;
               if (s == 7'h00) d = 12;
               if (d < 0) m_bad = 1;
               else begin
                  m_val = d; m_blank = (d == 12); m_valid = 1; m_pulse = 1;
                  m_c8 = m_c8 < 255 ? m_c8 + 1 : 255;
                  m_c2 = m_c2 < 3 ? m_c2 + 1 : 3;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (!reset) begin
      chk("value8", int'(bus8.value), m_val);
      chk("blank8", int'(bus8.blank), int'(m_blank));
      chk("valid8", int'(bus8.value_valid), int'(m_valid));
      chk("pulse8", int'(bus8.update_pulse), int'(m_pulse));
      chk("bad8", int'(bus8.bad_pattern), int'(m_bad));
      chk("count8", int'(bus8.change_count), m_c8);
      chk("value2", int'(bus2.value), m_val);
      chk("pulse2", int'(bus2.update_pulse), int'(m_pulse));
      chk("bad2", int'(bus2.bad_pattern), int'(m_bad));
      chk("count2", int'(bus2.change_count), m_c2);
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold(input logic [6:0] p, input int n);
      seg = p;
      wait_n(n);
   endtask

   task automatic lit(input string tag, input int v, input int bl, input int vv, input int pu, input int bd, input int c8, input int c2);
      chk({tag, "_value"}, int'(bus8.value), v);
      chk({tag, "_blank"}, int'(bus8.blank), bl);
      chk({tag, "_valid"}, int'(bus8.value_valid), vv);
      chk({tag, "_pulse"}, int'(bus8.update_pulse), pu);
      chk({tag, "_bad"}, int'(bus8.bad_pattern), bd);
      chk({tag, "_count8"}, int'(bus8.change_count), c8);
      chk({tag, "_count2"}, int'(bus2.change_count), c2);
   endtask

   initial begin
      wait_n(3);
      lit("reset", 0, 0, 0, 0, 0, 0, 0);
      reset = 0; seg = 7'h5B;
      wait_n(5);
      lit("edge5", 0, 0, 0, 0, 0, 0, 0);
      wait_n(1);
      lit("edge6", 2, 0, 1, 1, 0, 1, 1);
      wait_n(1);
      lit("edge7", 2, 0, 1, 0, 0, 1, 1);
      hold(7'h06, 8);
      lit("one", 1, 0, 1, 0, 0, 2, 2);
      hold(7'h7F, 2);
      hold(7'h06, 10);
      lit("glitch", 1, 0, 1, 0, 0, 2, 2);
      hold(7'h00, 8);
      lit("blank", 12, 1, 1, 0, 0, 3, 3);
      hold(7'h3F, 8);
      lit("zero", 0, 0, 1, 0, 0, 4, 3);
      hold(7'h49, 8);
      lit("illegal", 0, 0, 1, 0, 1, 4, 3);
      clr = 1; wait_n(1); clr = 0;
      lit("clear", 0, 0, 1, 0, 0, 0, 0);
      hold(7'h66, 5);
      clr = 1; wait_n(1); clr = 0;
      lit("clr_acc", 4, 0, 1, 1, 0, 1, 1);
      hold(7'h49, 5);
      clr = 1; wait_n(1); clr = 0;
      lit("clr_bad", 4, 0, 1, 0, 1, 0, 0);
      hold(7'h3F, 8);
      en = 0;
      hold(7'h66, 10);
      lit("frozen", 0, 0, 1, 0, 1, 1, 1);
      en = 1;
      wait_n(3);
      lit("reen3", 0, 0, 1, 0, 1, 1, 1);
      wait_n(1);
      lit("reen4", 4, 0, 1, 1, 1, 2, 2);
      en = 0; wait_n(3); en = 1; wait_n(8);
      lit("same", 4, 0, 1, 0, 1, 2, 2);
      hold(7'h07, 4);
      #1 reset = 1;
      #1 lit("midrst", 0, 0, 0, 0, 0, 0, 0);
      wait_n(2);
      reset = 0; seg = 7'h6F;
      wait_n(6);
      lit("after", 9, 0, 1, 1, 0, 1, 1);
      wait_n(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
